// File: rtl/reg_wb_ctrl_pkg.sv
// reg_wb_ctrl_pkg
// Shared definitions for the integer register file write-back path.
// Holds the register data width (RegBus), register address width
// (RegAddrBus), the architectural register count (RegNum), the width of
// each pending-write counter, and the write-back source identifiers.
package reg_wb_ctrl_pkg;

  localparam int RegBusW  = 32;
  localparam int RegAddrW = 5;
  localparam int RegNum   = 32;
  localparam int SbCntW   = 2;

  // Which write-back source was granted most recently; drives round-robin.
  typedef enum logic {
    SRC_ALU  = 1'b0,
    SRC_LOAD = 1'b1
  } wbSrc_e;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Pending-write scoreboard for the integer register file. Keeps one
// saturating-free counter per architectural register (x0 never tracked)
// counting reservations from issue that have not yet been written back.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   rsvValid_i/rsvAddr_i    issue stage reserves a destination register
//   rsvReady_o              reservation can be accepted (counter not full)
//   relValid_i/relAddr_i    register file write in progress (release)
//   qAddr1_i/qAddr2_i       query addresses
//   busy1_o/busy2_o         queried register still has an outstanding writer
//   flush_i                 clear all counters
//   sbErr_o                 sticky: release seen on a zero counter
module reg_scoreboard
  import reg_wb_ctrl_pkg::*;
#(
  parameter int ADDR_W   = RegAddrW,
  parameter int NUM_REGS = RegNum,
  parameter int CNT_W    = SbCntW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rsvValid_i,
  input  logic [ADDR_W-1:0] rsvAddr_i,
  output logic              rsvReady_o,
  input  logic              relValid_i,
  input  logic [ADDR_W-1:0] relAddr_i,
  input  logic [ADDR_W-1:0] qAddr1_i,
  input  logic [ADDR_W-1:0] qAddr2_i,
  output logic              busy1_o,
  output logic              busy2_o,
  input  logic              flush_i,
  output logic              sbErr_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic             sbErr_q, sbErr_d;
  logic             rsvFire, relFire;

  // Reservation handshake and release qualification. Writes to x0 never
  // touch the scoreboard, so x0 is always reservable and never released.
  always_comb begin
    rsvReady_o = (rsvAddr_i == '0) || (cnt_q[rsvAddr_i] != CntMax);
    rsvFire    = rsvValid_i && rsvReady_o && (rsvAddr_i != '0);
    relFire    = relValid_i && (relAddr_i != '0);
  end

  // Busy mirrors the register file's write bypass: a register being written
  // this cycle already has its value visible to readers, so it is not busy.
  always_comb begin
    busy1_o = (qAddr1_i != '0) && (cnt_q[qAddr1_i] != '0) &&
              !(relValid_i && (relAddr_i == qAddr1_i));
    busy2_o = (qAddr2_i != '0) && (cnt_q[qAddr2_i] != '0) &&
              !(relValid_i && (relAddr_i == qAddr2_i));
  end

  // Counter next-state. Flush wins over everything, including the release
  // of the write that is in flight during the flush cycle. A reserve and a
  // release on the same register cancel out. Releasing an empty counter
  // holds it at zero and latches the error flag.
  always_comb begin
    sbErr_d = sbErr_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush_i || (i == 0)) begin
        cnt_d[i] = '0;
      end else begin
        if (rsvFire && (rsvAddr_i == ADDR_W'(i)) &&
            !(relFire && (relAddr_i == ADDR_W'(i)))) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end else if (relFire && (relAddr_i == ADDR_W'(i)) &&
                     !(rsvFire && (rsvAddr_i == ADDR_W'(i)))) begin
          if (cnt_q[i] == '0) begin
            sbErr_d = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
      end
    end
  end

  // Counter and error flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
      sbErr_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sbErr_q <= sbErr_d;
    end
  end

  assign sbErr_o = sbErr_q;

endmodule

// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl
// Write-back controller owning the integer register file's single write
// port. Arbitrates round-robin between source 0 (ALU/branch) and source 1
// (load), registers the winning write for one cycle, and tracks pending
// writers through reg_scoreboard.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   s0_*/s1_*                       valid/ready write-back sources
//   w_addr/write_request/w_data     register file write port
//   rsv_valid/rsv_addr/rsv_ready    destination reservation from issue
//   q_addr1/q_addr2, busy1/busy2    scoreboard queries
//   flush                           drop all reservations
//   sb_err                          sticky scoreboard underflow flag
module reg_wb_ctrl
  import reg_wb_ctrl_pkg::*;
#(
  parameter int DATA_W   = RegBusW,
  parameter int ADDR_W   = RegAddrW,
  parameter int NUM_REGS = RegNum,
  parameter int CNT_W    = SbCntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  output logic              s1_ready,
  output logic [ADDR_W-1:0] w_addr,
  output logic              write_request,
  output logic [DATA_W-1:0] w_data,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ready,
  input  logic [ADDR_W-1:0] q_addr1,
  input  logic [ADDR_W-1:0] q_addr2,
  output logic              busy1,
  output logic              busy2,
  input  logic              flush,
  output logic              sb_err
);

  wbSrc_e            lastGrant_q, lastGrant_d;
  logic [ADDR_W-1:0] wAddr_q, wAddr_d;
  logic [DATA_W-1:0] wData_q, wData_d;
  logic              wReq_q, wReq_d;
  logic              grant0, grant1;

  // Round-robin arbitration. Source 0 wins unless source 1 is also valid
  // and source 0 was the last one granted; source 1 takes whatever is left,
  // so the two grants can never be high together.
  always_comb begin
    grant0 = s0_valid && (!s1_valid || (lastGrant_q == SRC_LOAD));
    grant1 = s1_valid && !grant0;
  end

  assign s0_ready = grant0;
  assign s1_ready = grant1;

  // Output stage next-state. A grant is always a transfer because grants
  // are only raised for valid sources. Address/data are captured for every
  // transfer, but a write to x0 never raises write_request. With no
  // transfer, write_request drops so it lasts exactly one cycle.
  always_comb begin
    lastGrant_d = lastGrant_q;
    wAddr_d     = wAddr_q;
    wData_d     = wData_q;
    wReq_d      = 1'b0;
    if (grant0) begin
      lastGrant_d = SRC_ALU;
      wAddr_d     = s0_addr;
      wData_d     = s0_data;
      wReq_d      = (s0_addr != '0);
    end else if (grant1) begin
      lastGrant_d = SRC_LOAD;
      wAddr_d     = s1_addr;
      wData_d     = s1_data;
      wReq_d      = (s1_addr != '0);
    end
  end

  // Arbitration history and registered write port. Reset drops any write
  // that would otherwise have been issued in the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant_q <= SRC_LOAD;
      wAddr_q     <= '0;
      wData_q     <= '0;
      wReq_q      <= 1'b0;
    end else begin
      lastGrant_q <= lastGrant_d;
      wAddr_q     <= wAddr_d;
      wData_q     <= wData_d;
      wReq_q      <= wReq_d;
    end
  end

  assign w_addr        = wAddr_q;
  assign w_data        = wData_q;
  assign write_request = wReq_q;

  // The write in progress on the register file port is the scoreboard
  // release for that register.
  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W)
  ) uScoreboard (
    .clk_i      (clk),
    .rst_i      (rst),
    .rsvValid_i (rsv_valid),
    .rsvAddr_i  (rsv_addr),
    .rsvReady_o (rsv_ready),
    .relValid_i (wReq_q),
    .relAddr_i  (wAddr_q),
    .qAddr1_i   (q_addr1),
    .qAddr2_i   (q_addr2),
    .busy1_o    (busy1),
    .busy2_o    (busy2),
    .flush_i    (flush),
    .sbErr_o    (sb_err)
  );

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// tb_reg_wb_ctrl
// Directed bench for reg_wb_ctrl: arbitration ties, single source, the
// scoreboard reserve/release/full cases, x0 writes, underflow error, flush
// and reset with a pending transfer.
module tb_reg_wb_ctrl;

  logic        clk;
  logic        rst;
  logic        s0_valid, s1_valid;
  logic [4:0]  s0_addr, s1_addr;
  logic [31:0] s0_data, s1_data;
  logic        s0_ready, s1_ready;
  logic [4:0]  w_addr;
  logic        write_request;
  logic [31:0] w_data;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        rsv_ready;
  logic [4:0]  q_addr1, q_addr2;
  logic        busy1, busy2;
  logic        flush;
  logic        sb_err;

  int totalChecks = 0;
  int badChecks   = 0;

  reg_wb_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .s0_valid      (s0_valid),
    .s0_addr       (s0_addr),
    .s0_data       (s0_data),
    .s0_ready      (s0_ready),
    .s1_valid      (s1_valid),
    .s1_addr       (s1_addr),
    .s1_data       (s1_data),
    .s1_ready      (s1_ready),
    .w_addr        (w_addr),
    .write_request (write_request),
    .w_data        (w_data),
    .rsv_valid     (rsv_valid),
    .rsv_addr      (rsv_addr),
    .rsv_ready     (rsv_ready),
    .q_addr1       (q_addr1),
    .q_addr2       (q_addr2),
    .busy1         (busy1),
    .busy2         (busy2),
    .flush         (flush),
    .sb_err        (sb_err)
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive both write-back sources.
  task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    s0_valid = v0;
    s0_addr  = a0;
    s0_data  = d0;
    s1_valid = v1;
    s1_addr  = a1;
    s1_data  = d1;
  endtask

  // One comparison against a bench-computed expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    assert (observed === expected) else begin
      badChecks++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Linear directed sequence.
  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    q_addr1   = '0;
    q_addr2   = '0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst_wreq", write_request, 32'd0);
    checkOutput("rst_waddr", w_addr, 32'd0);
    checkOutput("rst_wdata", w_data, 32'd0);
    checkOutput("rst_rsv_ready", rsv_ready, 32'd1);
    checkOutput("rst_busy1", busy1, 32'd0);
    checkOutput("rst_sb_err", sb_err, 32'd0);
    rst = 1'b0;

    $display("[TB] tie arbitration");
    applyStimulus(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("tie_s0_ready", s0_ready, (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("tie_s1_ready", s1_ready, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      checkOutput("tie_wreq", write_request, 32'd1);
      checkOutput("tie_waddr", w_addr, (i % 2 == 0) ? 32'd5 : 32'd6);
      checkOutput("tie_wdata", w_data, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("tie_idle_wreq", write_request, 32'd0);
    checkOutput("tie_sb_err", sb_err, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst2_sb_err", sb_err, 32'd0);

    $display("[TB] single source");
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    tick();
    rsv_valid = 1'b0;
    q_addr1   = 5'd7;
    #1;
    checkOutput("single_busy_before", busy1, 32'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEAD);
    #1;
    checkOutput("single_s1_ready", s1_ready, 32'd1);
    checkOutput("single_s0_ready", s0_ready, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("single_wreq", write_request, 32'd1);
    checkOutput("single_waddr", w_addr, 32'd7);
    checkOutput("single_wdata", w_data, 32'hDEAD);
    checkOutput("single_busy_bypass", busy1, 32'd0);
    tick();
    checkOutput("single_wreq_drop", write_request, 32'd0);
    checkOutput("single_busy_after", busy1, 32'd0);
    checkOutput("single_sb_err", sb_err, 32'd0);

    $display("[TB] scoreboard fill and drain");
    rsv_valid = 1'b1;
    rsv_addr  = 5'd3;
    q_addr1   = 5'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("sb_rsv_ready", rsv_ready, 32'd1);
      tick();
    end
    checkOutput("sb_full_ready", rsv_ready, 32'd0);
    checkOutput("sb_full_busy", busy1, 32'd1);
    tick();
    rsv_valid = 1'b0;
    #1;
    checkOutput("sb_no_wrap_busy", busy1, 32'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 5'd3, 32'h30 + k, 1'b0, 5'd0, 32'h0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("sb_rel_wreq", write_request, 32'd1);
      checkOutput("sb_rel_waddr", w_addr, 32'd3);
      checkOutput("sb_rel_busy_bypass", busy1, 32'd0);
      tick();
      checkOutput("sb_busy_after_rel", busy1, (k < 2) ? 32'd1 : 32'd0);
    end
    checkOutput("sb_drain_sb_err", sb_err, 32'd0);

    $display("[TB] same-cycle reserve and release");
    rsv_valid = 1'b1;
    rsv_addr  = 5'd4;
    tick();
    rsv_valid = 1'b0;
    q_addr2   = 5'd4;
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rsv_valid = 1'b1;
    rsv_addr  = 5'd4;
    #1;
    checkOutput("same_wreq", write_request, 32'd1);
    checkOutput("same_rsv_ready", rsv_ready, 32'd1);
    checkOutput("same_busy_bypass", busy2, 32'd0);
    tick();
    rsv_valid = 1'b0;
    #1;
    checkOutput("same_busy_after", busy2, 32'd1);
    applyStimulus(1'b1, 5'd4, 32'h45, 1'b0, 5'd0, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("same_drain_busy", busy2, 32'd0);
    checkOutput("same_sb_err", sb_err, 32'd0);

    $display("[TB] x0 write");
    applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("x0_s0_ready", s0_ready, 32'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("x0_wreq", write_request, 32'd0);
    tick();
    checkOutput("x0_sb_err", sb_err, 32'd0);

    $display("[TB] unreserved write error");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("err_wreq", write_request, 32'd1);
    checkOutput("err_waddr", w_addr, 32'd9);
    tick();
    checkOutput("err_sb_err", sb_err, 32'd1);
    tick();
    tick();
    checkOutput("err_sticky", sb_err, 32'd1);

    $display("[TB] flush");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("flush_pre_sb_err", sb_err, 32'd0);
    rsv_valid = 1'b1;
    rsv_addr  = 5'd8;
    tick();
    rsv_addr  = 5'd9;
    tick();
    rsv_valid = 1'b0;
    q_addr1   = 5'd8;
    q_addr2   = 5'd9;
    #1;
    checkOutput("flush_pre_busy1", busy1, 32'd1);
    checkOutput("flush_pre_busy2", busy2, 32'd1);
    applyStimulus(1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    flush = 1'b1;
    #1;
    checkOutput("flush_wreq", write_request, 32'd1);
    checkOutput("flush_wdata", w_data, 32'h88);
    tick();
    flush = 1'b0;
    #1;
    checkOutput("flush_busy1", busy1, 32'd0);
    checkOutput("flush_busy2", busy2, 32'd0);
    checkOutput("flush_sb_err", sb_err, 32'd0);
    checkOutput("flush_wreq_drop", write_request, 32'd0);

    $display("[TB] reset with pending transfer");
    applyStimulus(1'b1, 5'd10, 32'hAA, 1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("rstp_wreq", write_request, 32'd0);
    checkOutput("rstp_waddr", w_addr, 32'd0);
    tick();
    checkOutput("rstp_wreq_later", write_request, 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
